// File: rtl/decode_unit_pkg.sv
// Types shared by the 6502 core: bus widths, decoded mnemonic/mode enums and
// the sequencer state encoding.
package common_types;

  typedef logic [7:0]  data_t;
  typedef logic [15:0] addr_t;

  // Three-letter names keep debug printing aligned; XXX marks undocumented bytes.
  typedef enum logic [5:0] {
    ADC, AND, ASL, BCC, BCS, BEQ, BIT, BMI, BNE, BPL, BRK, BVC, BVS, CLC,
    CLD, CLI, CLV, CMP, CPX, CPY, DEC, DEX, DEY, EOR, INC, INX, INY, JMP,
    JSR, LDA, LDX, LDY, LSR, NOP, ORA, PHA, PHP, PLA, PLP, ROL, ROR, RTI,
    RTS, SBC, SEC, SED, SEI, STA, STX, STY, TAX, TAY, TSX, TXA, TXS, TYA,
    XXX
  } opc_t;

  typedef enum logic [3:0] {
    IMP, ACC, IMM, ZP, ZPX, ZPY, ABS, ABSX, ABSY, IND, INDX, INDY, REL
  } addmod_t;

  typedef enum logic [2:0] {
    ST_FETCH, ST_DECODE, ST_ADDR, ST_EXEC, ST_WBACK
  } state_t;

endpackage

// File: rtl/decode_unit_if.sv
// Opcode byte in, decoded mnemonic/mode out (combinational and held copies).
interface decode_unit_if;
  import common_types::*;

  data_t   instr;
  logic    load;
  opc_t    opcode;
  addmod_t mode;
  logic    illegal;
  opc_t    opcode_q;
  addmod_t mode_q;

  modport master (
    output instr, load,
    input  opcode, mode, illegal, opcode_q, mode_q
  );

  modport slave (
    input  instr, load,
    output opcode, mode, illegal, opcode_q, mode_q
  );

endinterface

// File: rtl/decode_unit.sv
// 6502 opcode decoder: zero-latency decode for the fetch state plus a held copy
// of the current instruction's decode for the later states.
module decode_unit
  import common_types::*;
(
  input  logic         clk,
  input  logic         rst,
  decode_unit_if.slave bus
);

  opc_t    opc_s;
  addmod_t mode_s;
  logic    ill_s;
  opc_t    opcode_d, opcode_q;
  addmod_t mode_d, mode_q;

  // Full opcode table; anything not listed is an undocumented NMOS byte.
  always_comb begin
    opc_s  = XXX;
    mode_s = IMP;
    ill_s  = 1'b0;
    case (bus.instr)
      8'h69: begin opc_s = ADC; mode_s = IMM;  end
      8'h65: begin opc_s = ADC; mode_s = ZP;   end
      8'h75: begin opc_s = ADC; mode_s = ZPX;  end
      8'h6D: begin opc_s = ADC; mode_s = ABS;  end
      8'h7D: begin opc_s = ADC; mode_s = ABSX; end
      8'h79: begin opc_s = ADC; mode_s = ABSY; end
      8'h61: begin opc_s = ADC; mode_s = INDX; end
      8'h71: begin opc_s = ADC; mode_s = INDY; end
      8'h29: begin opc_s = AND; mode_s = IMM;  end
      8'h25: begin opc_s = AND; mode_s = ZP;   end
      8'h35: begin opc_s = AND; mode_s = ZPX;  end
      8'h2D: begin opc_s = AND; mode_s = ABS;  end
      8'h3D: begin opc_s = AND; mode_s = ABSX; end
      8'h39: begin opc_s = AND; mode_s = ABSY; end
      8'h21: begin opc_s = AND; mode_s = INDX; end
      8'h31: begin opc_s = AND; mode_s = INDY; end
      8'h0A: begin opc_s = ASL; mode_s = ACC;  end
      8'h06: begin opc_s = ASL; mode_s = ZP;   end
      8'h16: begin opc_s = ASL; mode_s = ZPX;  end
      8'h0E: begin opc_s = ASL; mode_s = ABS;  end
      8'h1E: begin opc_s = ASL; mode_s = ABSX; end
      8'h90: begin opc_s = BCC; mode_s = REL;  end
      8'hB0: begin opc_s = BCS; mode_s = REL;  end
      8'hF0: begin opc_s = BEQ; mode_s = REL;  end
      8'h30: begin opc_s = BMI; mode_s = REL;  end
      8'hD0: begin opc_s = BNE; mode_s = REL;  end
      8'h10: begin opc_s = BPL; mode_s = REL;  end
      8'h50: begin opc_s = BVC; mode_s = REL;  end
      8'h70: begin opc_s = BVS; mode_s = REL;  end
      8'h24: begin opc_s = BIT; mode_s = ZP;   end
      8'h2C: begin opc_s = BIT; mode_s = ABS;  end
      8'h00: begin opc_s = BRK; mode_s = IMP;  end
      8'h18: begin opc_s = CLC; mode_s = IMP;  end
      8'hD8: begin opc_s = CLD; mode_s = IMP;  end
      8'h58: begin opc_s = CLI; mode_s = IMP;  end
      8'hB8: begin opc_s = CLV; mode_s = IMP;  end
      8'hC9: begin opc_s = CMP; mode_s = IMM;  end
      8'hC5: begin opc_s = CMP; mode_s = ZP;   end
      8'hD5: begin opc_s = CMP; mode_s = ZPX;  end
      8'hCD: begin opc_s = CMP; mode_s = ABS;  end
      8'hDD: begin opc_s = CMP; mode_s = ABSX; end
      8'hD9: begin opc_s = CMP; mode_s = ABSY; end
      8'hC1: begin opc_s = CMP; mode_s = INDX; end
      8'hD1: begin opc_s = CMP; mode_s = INDY; end
      8'hE0: begin opc_s = CPX; mode_s = IMM;  end
      8'hE4: begin opc_s = CPX; mode_s = ZP;   end
      8'hEC: begin opc_s = CPX; mode_s = ABS;  end
      8'hC0: begin opc_s = CPY; mode_s = IMM;  end
      8'hC4: begin opc_s = CPY; mode_s = ZP;   end
      8'hCC: begin opc_s = CPY; mode_s = ABS;  end
      8'hC6: begin opc_s = DEC; mode_s = ZP;   end
      8'hD6: begin opc_s = DEC; mode_s = ZPX;  end
      8'hCE: begin opc_s = DEC; mode_s = ABS;  end
      8'hDE: begin opc_s = DEC; mode_s = ABSX; end
      8'hCA: begin opc_s = DEX; mode_s = IMP;  end
      8'h88: begin opc_s = DEY; mode_s = IMP;  end
      8'h49: begin opc_s = EOR; mode_s = IMM;  end
      8'h45: begin opc_s = EOR; mode_s = ZP;   end
      8'h55: begin opc_s = EOR; mode_s = ZPX;  end
      8'h4D: begin opc_s = EOR; mode_s = ABS;  end
      8'h5D: begin opc_s = EOR; mode_s = ABSX; end
      8'h59: begin opc_s = EOR; mode_s = ABSY; end
      8'h41: begin opc_s = EOR; mode_s = INDX; end
      8'h51: begin opc_s = EOR; mode_s = INDY; end
      8'hE6: begin opc_s = INC; mode_s = ZP;   end
      8'hF6: begin opc_s = INC; mode_s = ZPX;  end
      8'hEE: begin opc_s = INC; mode_s = ABS;  end
      8'hFE: begin opc_s = INC; mode_s = ABSX; end
      8'hE8: begin opc_s = INX; mode_s = IMP;  end
      8'hC8: begin opc_s = INY; mode_s = IMP;  end
      8'h4C: begin opc_s = JMP; mode_s = ABS;  end
      8'h6C: begin opc_s = JMP; mode_s = IND;  end
      8'h20: begin opc_s = JSR; mode_s = ABS;  end
      8'hA9: begin opc_s = LDA; mode_s = IMM;  end
      8'hA5: begin opc_s = LDA; mode_s = ZP;   end
      8'hB5: begin opc_s = LDA; mode_s = ZPX;  end
      8'hAD: begin opc_s = LDA; mode_s = ABS;  end
      8'hBD: begin opc_s = LDA; mode_s = ABSX; end
      8'hB9: begin opc_s = LDA; mode_s = ABSY; end
      8'hA1: begin opc_s = LDA; mode_s = INDX; end
      8'hB1: begin opc_s = LDA; mode_s = INDY; end
      8'hA2: begin opc_s = LDX; mode_s = IMM;  end
      8'hA6: begin opc_s = LDX; mode_s = ZP;   end
      8'hB6: begin opc_s = LDX; mode_s = ZPY;  end
      8'hAE: begin opc_s = LDX; mode_s = ABS;  end
      8'hBE: begin opc_s = LDX; mode_s = ABSY; end
      8'hA0: begin opc_s = LDY; mode_s = IMM;  end
      8'hA4: begin opc_s = LDY; mode_s = ZP;   end
      8'hB4: begin opc_s = LDY; mode_s = ZPX;  end
      8'hAC: begin opc_s = LDY; mode_s = ABS;  end
      8'hBC: begin opc_s = LDY; mode_s = ABSX; end
      8'h4A: begin opc_s = LSR; mode_s = ACC;  end
      8'h46: begin opc_s = LSR; mode_s = ZP;   end
      8'h56: begin opc_s = LSR; mode_s = ZPX;  end
      8'h4E: begin opc_s = LSR; mode_s = ABS;  end
      8'h5E: begin opc_s = LSR; mode_s = ABSX; end
      8'hEA: begin opc_s = NOP; mode_s = IMP;  end
      8'h09: begin opc_s = ORA; mode_s = IMM;  end
      8'h05: begin opc_s = ORA; mode_s = ZP;   end
      8'h15: begin opc_s = ORA; mode_s = ZPX;  end
      8'h0D: begin opc_s = ORA; mode_s = ABS;  end
      8'h1D: begin opc_s = ORA; mode_s = ABSX; end
      8'h19: begin opc_s = ORA; mode_s = ABSY; end
      8'h01: begin opc_s = ORA; mode_s = INDX; end
      8'h11: begin opc_s = ORA; mode_s = INDY; end
      8'h48: begin opc_s = PHA; mode_s = IMP;  end
      8'h08: begin opc_s = PHP; mode_s = IMP;  end
      8'h68: begin opc_s = PLA; mode_s = IMP;  end
      8'h28: begin opc_s = PLP; mode_s = IMP;  end
      8'h2A: begin opc_s = ROL; mode_s = ACC;  end
      8'h26: begin opc_s = ROL; mode_s = ZP;   end
      8'h36: begin opc_s = ROL; mode_s = ZPX;  end
      8'h2E: begin opc_s = ROL; mode_s = ABS;  end
      8'h3E: begin opc_s = ROL; mode_s = ABSX; end
      8'h6A: begin opc_s = ROR; mode_s = ACC;  end
      8'h66: begin opc_s = ROR; mode_s = ZP;   end
      8'h76: begin opc_s = ROR; mode_s = ZPX;  end
      8'h6E: begin opc_s = ROR; mode_s = ABS;  end
      8'h7E: begin opc_s = ROR; mode_s = ABSX; end
      8'h40: begin opc_s = RTI; mode_s = IMP;  end
      8'h60: begin opc_s = RTS; mode_s = IMP;  end
      8'hE9: begin opc_s = SBC; mode_s = IMM;  end
      8'hE5: begin opc_s = SBC; mode_s = ZP;   end
      8'hF5: begin opc_s = SBC; mode_s = ZPX;  end
      8'hED: begin opc_s = SBC; mode_s = ABS;  end
      8'hFD: begin opc_s = SBC; mode_s = ABSX; end
      8'hF9: begin opc_s = SBC; mode_s = ABSY; end
      8'hE1: begin opc_s = SBC; mode_s = INDX; end
      8'hF1: begin opc_s = SBC; mode_s = INDY; end
      8'h38: begin opc_s = SEC; mode_s = IMP;  end
      8'hF8: begin opc_s = SED; mode_s = IMP;  end
      8'h78: begin opc_s = SEI; mode_s = IMP;  end
      8'h85: begin opc_s = STA; mode_s = ZP;   end
      8'h95: begin opc_s = STA; mode_s = ZPX;  end
      8'h8D: begin opc_s = STA; mode_s = ABS;  end
      8'h9D: begin opc_s = STA; mode_s = ABSX; end
      8'h99: begin opc_s = STA; mode_s = ABSY; end
      8'h81: begin opc_s = STA; mode_s = INDX; end
      8'h91: begin opc_s = STA; mode_s = INDY; end
      8'h86: begin opc_s = STX; mode_s = ZP;   end
      8'h96: begin opc_s = STX; mode_s = ZPY;  end
      8'h8E: begin opc_s = STX; mode_s = ABS;  end
      8'h84: begin opc_s = STY; mode_s = ZP;   end
      8'h94: begin opc_s = STY; mode_s = ZPX;  end
      8'h8C: begin opc_s = STY; mode_s = ABS;  end
      8'hAA: begin opc_s = TAX; mode_s = IMP;  end
      8'hA8: begin opc_s = TAY; mode_s = IMP;  end
      8'hBA: begin opc_s = TSX; mode_s = IMP;  end
      8'h8A: begin opc_s = TXA; mode_s = IMP;  end
      8'h9A: begin opc_s = TXS; mode_s = IMP;  end
      8'h98: begin opc_s = TYA; mode_s = IMP;  end
      default: begin opc_s = XXX; mode_s = IMP; ill_s = 1'b1; end
    endcase
  end

  // Held pair follows the live decode only when the sequencer asks for it.
  always_comb begin
    if (bus.load) begin
      opcode_d = opc_s;
      mode_d   = mode_s;
    end else begin
      opcode_d = opcode_q;
      mode_d   = mode_q;
    end
  end

  // Held decode register; reset parks it on a harmless NOP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opcode_q <= NOP;
      mode_q   <= IMP;
    end else begin
      opcode_q <= opcode_d;
      mode_q   <= mode_d;
    end
  end

  assign bus.opcode   = opc_s;
  assign bus.mode     = mode_s;
  assign bus.illegal  = ill_s;
  assign bus.opcode_q = opcode_q;
  assign bus.mode_q   = mode_q;

endmodule

// File: tb/tb_decode_unit.sv
// Bench for decode_unit: directed checks from the opcode map plus randomized
// traffic compared every cycle against a grid-based 6502 decode model.
module tb_decode_unit;
  import common_types::*;

  typedef struct packed {
    opc_t    o;
    addmod_t m;
    logic    ill;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nvec = 0;
  int   nerr = 0;
  bit   cmp_en = 1'b0;
  opc_t    exp_oq = NOP;
  addmod_t exp_mq = IMP;

  decode_unit_if bus ();

  decode_unit u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Model built from the aaabbbcc opcode grid rather than a flat table.
  function automatic exp_t model(input logic [7:0] b);
    exp_t e;
    logic [2:0] a, m;
    a = b[7:5];
    m = b[4:2];
    e = '{o: XXX, m: IMP, ill: 1'b1};
    case (b[1:0])
      2'b01: begin
        if (b != 8'h89) begin
          e.ill = 1'b0;
          case (a)
            3'd0: e.o = ORA;  3'd1: e.o = AND;  3'd2: e.o = EOR;  3'd3: e.o = ADC;
            3'd4: e.o = STA;  3'd5: e.o = LDA;  3'd6: e.o = CMP;  default: e.o = SBC;
          endcase
          case (m)
            3'd0: e.m = INDX; 3'd1: e.m = ZP;   3'd2: e.m = IMM;  3'd3: e.m = ABS;
            3'd4: e.m = INDY; 3'd5: e.m = ZPX;  3'd6: e.m = ABSY; default: e.m = ABSX;
          endcase
        end
      end
      2'b10: begin
        case (a)
          3'd0: e.o = ASL;  3'd1: e.o = ROL;  3'd2: e.o = LSR;  3'd3: e.o = ROR;
          3'd4: e.o = STX;  3'd5: e.o = LDX;  3'd6: e.o = DEC;  default: e.o = INC;
        endcase
        e.ill = 1'b0;
        case (m)
          3'd0: if (a == 3'd5) e.m = IMM; else e.ill = 1'b1;
          3'd1: e.m = ZP;
          3'd2: begin
            if (a < 3'd4) e.m = ACC;
            else begin
              case (a)
                3'd4: e.o = TXA;  3'd5: e.o = TAX;  3'd6: e.o = DEX;  default: e.o = NOP;
              endcase
            end
          end
          3'd3: e.m = ABS;
          3'd5: e.m = (a == 3'd4 || a == 3'd5) ? ZPY : ZPX;
          3'd6: begin
            if (a == 3'd4) e.o = TXS;
            else if (a == 3'd5) e.o = TSX;
            else e.ill = 1'b1;
          end
          3'd7: begin
            if (a == 3'd4) e.ill = 1'b1;
            else e.m = (a == 3'd5) ? ABSY : ABSX;
          end
          default: e.ill = 1'b1;
        endcase
      end
      2'b00: begin
        e.ill = 1'b0;
        case (m)
          3'd4: begin
            e.m = REL;
            case (a)
              3'd0: e.o = BPL;  3'd1: e.o = BMI;  3'd2: e.o = BVC;  3'd3: e.o = BVS;
              3'd4: e.o = BCC;  3'd5: e.o = BCS;  3'd6: e.o = BNE;  default: e.o = BEQ;
            endcase
          end
          3'd6: begin
            case (a)
              3'd0: e.o = CLC;  3'd1: e.o = SEC;  3'd2: e.o = CLI;  3'd3: e.o = SEI;
              3'd4: e.o = TYA;  3'd5: e.o = CLV;  3'd6: e.o = CLD;  default: e.o = SED;
            endcase
          end
          3'd2: begin
            case (a)
              3'd0: e.o = PHP;  3'd1: e.o = PLP;  3'd2: e.o = PHA;  3'd3: e.o = PLA;
              3'd4: e.o = DEY;  3'd5: e.o = TAY;  3'd6: e.o = INY;  default: e.o = INX;
            endcase
          end
          3'd0: begin
            case (a)
              3'd0: e.o = BRK;
              3'd1: begin e.o = JSR; e.m = ABS; end
              3'd2: e.o = RTI;
              3'd3: e.o = RTS;
              3'd5: begin e.o = LDY; e.m = IMM; end
              3'd6: begin e.o = CPY; e.m = IMM; end
              3'd7: begin e.o = CPX; e.m = IMM; end
              default: e.ill = 1'b1;
            endcase
          end
          3'd1, 3'd3: begin
            e.m = (m == 3'd1) ? ZP : ABS;
            case (a)
              3'd1: e.o = BIT;
              3'd2: if (m == 3'd3) e.o = JMP; else e.ill = 1'b1;
              3'd3: if (m == 3'd3) begin e.o = JMP; e.m = IND; end else e.ill = 1'b1;
              3'd4: e.o = STY;
              3'd5: e.o = LDY;
              3'd6: e.o = CPY;
              3'd7: e.o = CPX;
              default: e.ill = 1'b1;
            endcase
          end
          3'd5: begin
            e.m = ZPX;
            if (a == 3'd4) e.o = STY;
            else if (a == 3'd5) e.o = LDY;
            else e.ill = 1'b1;
          end
          default: begin
            e.m = ABSX;
            if (a == 3'd5) e.o = LDY; else e.ill = 1'b1;
          end
        endcase
      end
      default: e.ill = 1'b1;
    endcase
    if (e.ill) begin
      e.o = XXX;
      e.m = IMP;
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected held pair, tracked from reset and load alone.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_oq <= NOP;
      exp_mq <= IMP;
    end else if (bus.load) begin
      exp_oq <= model(bus.instr).o;
      exp_mq <= model(bus.instr).m;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      exp_t e;
      e = model(bus.instr);
      chk("cyc_opcode",   32'(bus.opcode),   32'(e.o));
      chk("cyc_mode",     32'(bus.mode),     32'(e.m));
      chk("cyc_illegal",  32'(bus.illegal),  32'(e.ill));
      chk("cyc_opcode_q", 32'(bus.opcode_q), 32'(exp_oq));
      chk("cyc_mode_q",   32'(bus.mode_q),   32'(exp_mq));
    end
  end

  typedef struct {
    logic [7:0] b;
    opc_t       o;
    addmod_t    m;
    logic       ill;
  } pin_t;

  pin_t pins[$] = '{
    '{8'hA2, LDX, IMM,  1'b0}, '{8'hA6, LDX, ZP,   1'b0}, '{8'hAE, LDX, ABS,  1'b0},
    '{8'hB6, LDX, ZPY,  1'b0}, '{8'hBE, LDX, ABSY, 1'b0}, '{8'h4C, JMP, ABS,  1'b0},
    '{8'h6C, JMP, IND,  1'b0}, '{8'hE8, INX, IMP,  1'b0}, '{8'hEA, NOP, IMP,  1'b0},
    '{8'h0A, ASL, ACC,  1'b0}, '{8'hD0, BNE, REL,  1'b0}, '{8'hB1, LDA, INDY, 1'b0},
    '{8'h81, STA, INDX, 1'b0}, '{8'h20, JSR, ABS,  1'b0}, '{8'h00, BRK, IMP,  1'b0},
    '{8'h9D, STA, ABSX, 1'b0}, '{8'h02, XXX, IMP,  1'b1}, '{8'h03, XXX, IMP,  1'b1},
    '{8'hFF, XXX, IMP,  1'b1}, '{8'h89, XXX, IMP,  1'b1}, '{8'h9E, XXX, IMP,  1'b1}
  };

  initial begin
    int legal;
    bus.instr = 8'h00;
    bus.load  = 1'b0;
    rst       = 1'b1;
    tick();
    chk("rst_opcode_q", 32'(bus.opcode_q), 32'(NOP));
    chk("rst_mode_q",   32'(bus.mode_q),   32'(IMP));
    rst = 1'b0;
    cmp_en = 1'b1;

    // Literal expectations pin both the DUT and the model.
    foreach (pins[i]) begin
      exp_t e;
      bus.instr = pins[i].b;
      #1;
      e = model(pins[i].b);
      chk("pin_opcode",  32'(bus.opcode),  32'(pins[i].o));
      chk("pin_mode",    32'(bus.mode),    32'(pins[i].m));
      chk("pin_illegal", 32'(bus.illegal), 32'(pins[i].ill));
      chk("model_pin",   32'({e.o, e.m, e.ill}), 32'({pins[i].o, pins[i].m, pins[i].ill}));
    end

    legal = 0;
    for (int b = 0; b < 256; b++) begin
      bus.instr = 8'(b);
      #1;
      if (bus.illegal === 1'b0) legal++;
    end
    chk("legal_count", 32'(legal), 32'd151);

    // Hold behaviour.
    tick();
    bus.instr = 8'hE8;
    bus.load  = 1'b1;
    tick();
    chk("hold_cap", 32'(bus.opcode_q), 32'(INX));
    bus.instr = 8'h4C;
    bus.load  = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("hold_opcode_q", 32'(bus.opcode_q), 32'(INX));
      chk("hold_mode_q",   32'(bus.mode_q),   32'(IMP));
      chk("hold_opcode",   32'(bus.opcode),   32'(JMP));
    end

    // Asynchronous reset between edges.
    bus.instr = 8'hA6;
    bus.load  = 1'b1;
    tick();
    chk("cap_ldx", 32'({bus.opcode_q, bus.mode_q}), 32'({LDX, ZP}));
    #2;
    rst = 1'b1;
    #1;
    chk("async_opcode_q", 32'(bus.opcode_q), 32'(NOP));
    chk("async_mode_q",   32'(bus.mode_q),   32'(IMP));
    tick();
    tick();
    chk("rst_load_ignored", 32'({bus.opcode_q, bus.mode_q}), 32'({NOP, IMP}));
    rst = 1'b0;
    bus.instr = 8'hA9;
    bus.load  = 1'b1;
    tick();
    chk("release_opcode_q", 32'(bus.opcode_q), 32'(LDA));
    chk("release_mode_q",   32'(bus.mode_q),   32'(IMM));

    // Randomized traffic with occasional reset pulses.
    for (int k = 0; k < 400; k++) begin
      bus.instr = 8'($urandom_range(0, 255));
      bus.load  = 1'($urandom_range(0, 1));
      rst       = ($urandom_range(0, 31) == 0) ? 1'b1 : 1'b0;
      tick();
    end
    rst = 1'b0;
    tick();
    cmp_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
